// File: rtl/axis_parity_checker_pkg.sv
// Shared definitions for the AXI-Stream parity checker.
//   state_t            : response FSM states (RECV, CODE, LEN)
//   DEFAULT_PASS_CODE  : status beat sent when a packet passes
//   DEFAULT_FAIL_CODE  : status beat sent when a packet fails
//   xor_reduce()       : parity of a beat, zero-extended to XOR_MAX_W
package axis_parity_checker_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        CODE = 2'd1,
        LEN  = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_PASS_CODE = 8'hAB;
    localparam logic [7:0] DEFAULT_FAIL_CODE = 8'hFF;

    // Widest beat the helper handles; zero padding does not change parity.
    localparam int XOR_MAX_W = 1024;

    function automatic logic xor_reduce(input logic [XOR_MAX_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/axis_parity_checker_if.sv
// AXI-Stream bundle used on both sides of the parity checker.
//   tvalid/tdata/tlast : driven by the master
//   tready             : driven by the slave
interface axis_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tready;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_parity_checker_accum.sv
// Running parity and beat count for the packet currently being received.
//   in_clock, in_reset : clock, async active-high reset
//   accept             : a slave beat is being accepted this cycle
//   last               : the accepted beat ends the packet (clears state)
//   data               : beat payload
//   parity_final       : parity including the current beat
//   count_beat         : beat count including the current beat, sized to DATA_W
module axis_parity_checker_accum
    import axis_parity_checker_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              in_clock,
    input  logic              in_reset,
    input  logic              accept,
    input  logic              last,
    input  logic [DATA_W-1:0] data,
    output logic              parity_final,
    output logic [DATA_W-1:0] count_beat
);

    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat_parity;

    assign beat_parity  = xor_reduce(XOR_MAX_W'(data));
    assign parity_final = acc ^ beat_parity;

    // Count saturates; parity keeps accumulating regardless.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    generate
        if (CNT_W >= DATA_W) begin : g_trunc
            assign count_beat = cnt_inc[DATA_W-1:0];
        end else begin : g_ext
            assign count_beat = {{(DATA_W-CNT_W){1'b0}}, cnt_inc};
        end
    endgenerate

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            acc <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc <= 1'b0;
                cnt <= '0;
            end else begin
                acc <= parity_final;
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/axis_parity_checker.sv
// Packet parity checker: accumulates XOR parity over every bit of an incoming
// AXI-Stream packet and answers each packet with a two-beat response
// (status code, then beat count). Counts failing packets, saturating.
//   in_clock, in_reset : clock, async active-high reset
//   axis_s             : packet input stream (slave)
//   axis_m             : response output stream (master, registered)
//   err_count          : failed packets since reset, saturating
//
// state | meaning
// RECV  | accepting packet beats, no response pending
// CODE  | status beat presented, waiting for downstream ready
// LEN   | count beat presented, waiting for downstream ready
module axis_parity_checker
    import axis_parity_checker_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter int         ODD_PARITY = 0,
    parameter int         CNT_W      = 16,
    parameter int         ERR_W      = 8,
    parameter logic [7:0] PASS_CODE  = DEFAULT_PASS_CODE,
    parameter logic [7:0] FAIL_CODE  = DEFAULT_FAIL_CODE
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    axis_parity_checker_if.slave    axis_s,
    axis_parity_checker_if.master   axis_m,
    output logic [ERR_W-1:0]        err_count
);

    localparam logic [DATA_W-1:0] PASS_BEAT = DATA_W'(PASS_CODE);
    localparam logic [DATA_W-1:0] FAIL_BEAT = DATA_W'(FAIL_CODE);
    localparam logic              ODD_BIT   = (ODD_PARITY != 0);

    state_t            state;
    logic              s_tready;
    logic              accept;
    logic              parity_final;
    logic              fail;
    logic [DATA_W-1:0] count_beat;
    logic [DATA_W-1:0] count_q;
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic [ERR_W-1:0]  err_q;

    assign s_tready = (state == RECV);
    assign accept   = axis_s.tvalid & s_tready;
    assign fail     = (parity_final != ODD_BIT);

    axis_parity_checker_accum #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_accum (
        .in_clock     (in_clock),
        .in_reset     (in_reset),
        .accept       (accept),
        .last         (axis_s.tlast),
        .data         (axis_s.tdata),
        .parity_final (parity_final),
        .count_beat   (count_beat)
    );

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state    <= RECV;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            case (state)
                RECV: begin
                    if (accept && axis_s.tlast) begin
                        m_tdata  <= fail ? FAIL_BEAT : PASS_BEAT;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                        count_q  <= count_beat;
                        if (fail && (err_q != {ERR_W{1'b1}})) begin
                            err_q <= err_q + ERR_W'(1);
                        end
                        state <= CODE;
                    end
                end
                CODE: begin
                    if (axis_m.tready) begin
                        m_tdata <= count_q;
                        m_tlast <= 1'b1;
                        state   <= LEN;
                    end
                end
                LEN: begin
                    if (axis_m.tready) begin
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        state    <= RECV;
                    end
                end
                default: begin
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                    state    <= RECV;
                end
            endcase
        end
    end

    assign axis_s.tready = s_tready;
    assign axis_m.tvalid = m_tvalid;
    assign axis_m.tdata  = m_tdata;
    assign axis_m.tlast  = m_tlast;
    assign err_count     = err_q;

endmodule

// File: tb/tb_axis_parity_checker.sv
// Bench for axis_parity_checker. Three instances share one stimulus:
//   dut0 even parity, dut1 odd parity, dut2 even parity with a 2-bit error counter.
// A queue-based model predicts every response beat and the error counts.
module tb_axis_parity_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tv  = 1'b0;
    logic [7:0] td  = 8'h00;
    logic       tl  = 1'b0;
    logic       mr  = 1'b0;
    bit         rand_mr = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_parity_checker_if #(.DATA_W(8)) s0 ();
    axis_parity_checker_if #(.DATA_W(8)) m0 ();
    axis_parity_checker_if #(.DATA_W(8)) s1 ();
    axis_parity_checker_if #(.DATA_W(8)) m1 ();
    axis_parity_checker_if #(.DATA_W(8)) s2 ();
    axis_parity_checker_if #(.DATA_W(8)) m2 ();

    logic [7:0] err0;
    logic [7:0] err1;
    logic [1:0] err2;

    assign s0.tvalid = tv;  assign s0.tdata = td;  assign s0.tlast = tl;  assign m0.tready = mr;
    assign s1.tvalid = tv;  assign s1.tdata = td;  assign s1.tlast = tl;  assign m1.tready = mr;
    assign s2.tvalid = tv;  assign s2.tdata = td;  assign s2.tlast = tl;  assign m2.tready = mr;

    axis_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(16), .ERR_W(8),
                          .PASS_CODE(8'hAB), .FAIL_CODE(8'hFF)) dut0 (
        .in_clock(clk), .in_reset(rst), .axis_s(s0.slave), .axis_m(m0.master), .err_count(err0));
    axis_parity_checker #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(16), .ERR_W(8),
                          .PASS_CODE(8'hAB), .FAIL_CODE(8'hFF)) dut1 (
        .in_clock(clk), .in_reset(rst), .axis_s(s1.slave), .axis_m(m1.master), .err_count(err1));
    axis_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(16), .ERR_W(2),
                          .PASS_CODE(8'hAB), .FAIL_CODE(8'hFF)) dut2 (
        .in_clock(clk), .in_reset(rst), .axis_s(s2.slave), .axis_m(m2.master), .err_count(err2));

    logic       o_valid [3];
    logic       o_last  [3];
    logic       o_ready [3];
    logic [7:0] o_data  [3];
    logic [7:0] o_err   [3];

    assign o_valid[0] = m0.tvalid; assign o_last[0] = m0.tlast; assign o_ready[0] = s0.tready;
    assign o_valid[1] = m1.tvalid; assign o_last[1] = m1.tlast; assign o_ready[1] = s1.tready;
    assign o_valid[2] = m2.tvalid; assign o_last[2] = m2.tlast; assign o_ready[2] = s2.tready;
    assign o_data[0]  = m0.tdata;  assign o_data[1] = m1.tdata;  assign o_data[2] = m2.tdata;
    assign o_err[0]   = err0;      assign o_err[1]  = err1;      assign o_err[2]  = {6'd0, err2};

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t q [3][$];
    int    e_exp [3];
    bit    macc;
    int    mcnt;
    localparam bit ODD  [3] = '{1'b0, 1'b1, 1'b0};
    localparam int EMAX [3] = '{255, 255, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit         busy;
        bit         fl;
        logic [7:0] cb;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                q[i].delete();
                e_exp[i] = 0;
                chk($sformatf("rst_tvalid[%0d]", i), 32'(o_valid[i]), 32'd0);
                chk($sformatf("rst_tdata[%0d]", i), 32'(o_data[i]), 32'd0);
                chk($sformatf("rst_tlast[%0d]", i), 32'(o_last[i]), 32'd0);
                chk($sformatf("rst_tready[%0d]", i), 32'(o_ready[i]), 32'd1);
                chk($sformatf("rst_err[%0d]", i), 32'(o_err[i]), 32'd0);
            end
            macc = 1'b0;
            mcnt = 0;
        end else begin
            busy = (q[0].size() != 0);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("tready[%0d]", i), 32'(o_ready[i]), busy ? 32'd0 : 32'd1);
                chk($sformatf("tvalid[%0d]", i), 32'(o_valid[i]), busy ? 32'd1 : 32'd0);
                if (busy) begin
                    chk($sformatf("tdata[%0d]", i), 32'(o_data[i]), 32'(q[i][0].data));
                    chk($sformatf("tlast[%0d]", i), 32'(o_last[i]), 32'(q[i][0].last));
                end
                chk($sformatf("err[%0d]", i), 32'(o_err[i]), 32'(e_exp[i]));
            end
            if (!busy && tv) begin
                macc = macc ^ (^td);
                if (mcnt < 65535) mcnt++;
                if (tl) begin
                    cb = mcnt[7:0];
                    for (int i = 0; i < 3; i++) begin
                        fl = (macc != ODD[i]);
                        q[i].push_back('{fl ? 8'hFF : 8'hAB, 1'b0});
                        q[i].push_back('{cb, 1'b1});
                        if (fl && e_exp[i] < EMAX[i]) e_exp[i]++;
                    end
                    macc = 1'b0;
                    mcnt = 0;
                end
            end else if (busy && mr) begin
                for (int i = 0; i < 3; i++) void'(q[i].pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    logic [7:0] r_st [3];
    logic [7:0] r_cn [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        bit ok = 1'b0;
        tv = 1'b1; td = d; tl = last;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s0.tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout actual=no_tready required=tready");
        end
        tick();
        tv = 1'b0; tl = 1'b0;
    endtask

    task automatic collect();
        bit ok;
        mr = 1'b1;
        for (int b = 0; b < 2; b++) begin
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (m0.tvalid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                failures++;
                $display("FAIL collect_timeout actual=no_tvalid required=tvalid");
            end
            for (int i = 0; i < 3; i++) begin
                if (b == 0) r_st[i] = o_data[i];
                else        r_cn[i] = o_data[i];
            end
            tick();
        end
        mr = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mr) mr = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int  len;
        bit  ok;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", 32'(s0.tready), 32'd1);
        chk("post_rst_tvalid", 32'(m0.tvalid), 32'd0);
        tick();

        // single beat 03, even parity passes
        send_beat(8'h03, 1'b1);
        collect();
        chk("t1_status", 32'(r_st[0]), 32'hAB);
        chk("t1_count", 32'(r_cn[0]), 32'h01);
        chk("t1_err", 32'(err0), 32'd0);
        chk("t1_odd_status", 32'(r_st[1]), 32'hFF);

        // 01,00,00: parity 1, even fails
        send_beat(8'h01, 1'b0);
        send_beat(8'h00, 1'b0);
        send_beat(8'h00, 1'b1);
        collect();
        chk("t2_status", 32'(r_st[0]), 32'hFF);
        chk("t2_count", 32'(r_cn[0]), 32'h03);
        chk("t2_err", 32'(err0), 32'd1);

        // odd-parity instance
        send_beat(8'h01, 1'b0);
        send_beat(8'h80, 1'b0);
        send_beat(8'h80, 1'b1);
        collect();
        chk("t3a_odd_status", 32'(r_st[1]), 32'hAB);
        chk("t3a_odd_count", 32'(r_cn[1]), 32'h03);
        send_beat(8'h0F, 1'b1);
        collect();
        chk("t3b_odd_status", 32'(r_st[1]), 32'hFF);
        chk("t3b_odd_count", 32'(r_cn[1]), 32'h01);
        chk("t3_odd_err", 32'(err1), 32'd2);

        // downstream stall during CODE
        send_beat(8'h03, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_stall_tvalid", 32'(m0.tvalid), 32'd1);
            chk("t4_stall_tdata", 32'(m0.tdata), 32'hAB);
            chk("t4_stall_tlast", 32'(m0.tlast), 32'd0);
            chk("t4_stall_tready", 32'(s0.tready), 32'd0);
        end
        tick();
        collect();
        chk("t4_count", 32'(r_cn[0]), 32'h01);

        // reset in the middle of a packet
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        send_beat(8'h00, 1'b1);
        collect();
        chk("t5_status", 32'(r_st[0]), 32'hAB);
        chk("t5_count", 32'(r_cn[0]), 32'h01);
        chk("t5_err", 32'(err0), 32'd0);

        // error counter saturation on the 2-bit instance
        for (int p = 0; p < 5; p++) begin
            send_beat(8'h01, 1'b1);
            collect();
        end
        chk("t6_err_sat", 32'(err2), 32'd3);
        chk("t6_err_wide", 32'(err0), 32'd5);

        // long packet: count beat wraps to the low byte
        for (int b = 0; b < 260; b++) send_beat(8'(b), b == 259);
        collect();
        chk("t7_count_trunc", 32'(r_cn[0]), 32'h04);

        // random traffic with random backpressure
        rand_mr = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_beat(8'($urandom), b == len - 1);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_mr = 1'b0;
        tick();
        mr = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (q[0].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", 32'(ok), 32'd1);
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
